// File: rtl/rr5_arbiter.sv
// Five-way round-robin arbiter with a one-hot rotating priority pointer; state updates on the falling clock edge.
// Optional grant timeout (cnt/mask/tmo revoke path) is built when RR5_TIMEOUT_EN is defined.
module rr5_arbiter #(
  parameter int QUANTUM = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [4:0] i_req,
  output logic [4:0] o_gnt,
  output logic [2:0] o_gid,
  output logic       o_busy,
  output logic [4:0] o_ptr,
  output logic       o_max,
  output logic       o_tmo
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [4:0] r_gnt, w_gnt_nxt;
  logic [4:0] r_ptr, w_ptr_nxt;
  logic [4:0] w_mask, w_elig, w_win, w_scan;
  logic       w_hold_req;

  if (QUANTUM < 2 || QUANTUM > 15) begin : g_bad_quantum
    $error("rr5_arbiter: QUANTUM must be in 2..15");
  end

  function automatic logic [4:0] rotl1(input logic [4:0] v);
    return {v[3:0], v[4]};
  endfunction

`ifdef RR5_TIMEOUT_EN
  localparam logic [3:0] QLAST = 4'(QUANTUM - 1);
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [4:0] r_mask, w_mask_nxt;
  logic       r_tmo, w_tmo_nxt;
  assign w_mask = r_mask;
  assign o_tmo  = r_tmo;
`else
  assign w_mask = '0;
  assign o_tmo  = 1'b0;
`endif

  assign w_elig     = i_req & ~w_mask;
  assign w_hold_req = |(i_req & r_gnt);

  // Walk the pointer bit around the ring; the first eligible position wins.
  always_comb begin
    w_win  = '0;
    w_scan = r_ptr;
    for (int k = 0; k < 5; k++) begin
      if (w_win == '0 && (w_scan & w_elig) != '0) w_win = w_scan;
      w_scan = rotl1(w_scan);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
`ifdef RR5_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask & i_req;  // a dropped request re-arms its requester, even when frozen
    w_tmo_nxt   = 1'b0;
`endif
    if (i_en) begin
      case (r_state)
        IDLE: begin
          if (w_elig != '0) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = w_win;
`ifdef RR5_TIMEOUT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end
        GRANT: begin
          if (!w_hold_req) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_ptr_nxt   = rotl1(r_gnt);
          end
`ifdef RR5_TIMEOUT_EN
          else if (r_cnt == QLAST) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_ptr_nxt   = rotl1(r_gnt);
            w_mask_nxt  = (r_mask & i_req) | r_gnt;
            w_tmo_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + 4'd1;
          end
`endif
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= 5'b00001;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

`ifdef RR5_TIMEOUT_EN
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_mask <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_mask <= w_mask_nxt;
      r_tmo  <= w_tmo_nxt;
    end
  end
`endif

  always_comb begin
    o_gid = 3'd0;
    case (r_gnt)
      5'b00010: o_gid = 3'd1;
      5'b00100: o_gid = 3'd2;
      5'b01000: o_gid = 3'd3;
      5'b10000: o_gid = 3'd4;
      default:  o_gid = 3'd0;
    endcase
  end

  assign o_gnt  = r_gnt;
  assign o_busy = |r_gnt;
  assign o_ptr  = r_ptr;
  assign o_max  = r_ptr[4];

endmodule
